ahb_sram_responder: RTL and testbench

AHB slave-side responder that converts bus transfers into synchronous single-port SRAM accesses, with configurable wait states, HSIZE-based byte-lane writes, and a two-cycle ERROR response. It sits between the AHB interconnect's slave port (HSEL_Sx, HREADY_Sx, HRESP_Sx, HRDATA_Sx) and an IM/DM-style SRAM macro. It is the responder for the transfers issued by the CPU-side master wrappers.

---
 rtl/ahb_sram_responder.sv | 180 ++++++++++++++++++
 tb/tb_ahb_sram_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_responder.sv
// AHB slave responder mapping bus transfers onto a synchronous single-port SRAM,
// with configurable data-phase wait states, byte-lane write strobes and a two-cycle ERROR.
module ahb_sram_responder #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] MEM_BYTES   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADY_out,
    output logic [1:0]  HRESP,
    output logic [31:0] MAddress,
    output logic [31:0] MWrite_data,
    output logic [3:0]  Mwrite,
    output logic        Menable,
    input  logic [31:0] MRead_data
);

    localparam logic [4:0] WAIT_CNT   = 5'(WAIT_STATES);
    localparam logic [2:0] SIZE_BYTE  = 3'b000;
    localparam logic [2:0] SIZE_HALF  = 3'b001;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  wait_cnt_reg, wait_cnt_next;
    logic [29:0] word_addr_reg, word_addr_next;
    logic [1:0]  byte_off_reg, byte_off_next;
    logic [2:0]  size_reg, size_next;

    logic        trans_active;
    logic        accept;
    logic        illegal;
    logic        data_ready;
    logic        read_ready;
    logic        write_ready;
    logic [3:0]  lane_strb;

    // READ runs one cycle past the counter reaching zero; bit 4 marks that underflow.
    assign read_ready   = (state_reg == ST_READ)  && wait_cnt_reg[4];
    assign write_ready  = (state_reg == ST_WRITE) && (wait_cnt_reg == 5'd0);

    always_comb begin
        data_ready = 1'b0;
        case (state_reg)
            ST_IDLE:  data_ready = 1'b1;
            ST_READ:  data_ready = read_ready;
            ST_WRITE: data_ready = write_ready;
            ST_ERR1:  data_ready = 1'b0;
            ST_ERR2:  data_ready = 1'b1;
            default:  data_ready = 1'b1;
        endcase
    end

    assign trans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    assign accept       = HSEL && trans_active && HREADY && data_ready;

    assign illegal = (HSIZE > SIZE_WORD)
                  || ((HSIZE == SIZE_HALF) && HADDR[0])
                  || ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00))
                  || (HADDR >= MEM_BYTES);

    // Byte-lane enables from the latched size and offset; only legal sizes reach here.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_strb[gi] = (size_reg == SIZE_WORD)
                                || ((size_reg == SIZE_HALF) && (byte_off_reg[1] == LANE[1]))
                                || ((size_reg == SIZE_BYTE) && (byte_off_reg == LANE));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= 5'd0;
            word_addr_reg <= 30'd0;
            byte_off_reg  <= 2'd0;
            size_reg      <= 3'd0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            word_addr_reg <= word_addr_next;
            byte_off_reg  <= byte_off_next;
            size_reg      <= size_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        word_addr_next = word_addr_reg;
        byte_off_next  = byte_off_reg;
        size_next      = size_reg;

        case (state_reg)
            ST_READ: begin
                if (!wait_cnt_reg[4]) begin
                    wait_cnt_next = wait_cnt_reg - 5'd1;
                end
            end
            ST_WRITE: begin
                if (wait_cnt_reg != 5'd0) begin
                    wait_cnt_next = wait_cnt_reg - 5'd1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: ;
        endcase

        // The final data-phase cycle doubles as the next address phase.
        if (data_ready) begin
            if (accept) begin
                word_addr_next = HADDR[31:2];
                byte_off_next  = HADDR[1:0];
                size_next      = HSIZE;
                wait_cnt_next  = WAIT_CNT;
                if (illegal) begin
                    state_next = ST_ERR1;
                end else if (HWRITE) begin
                    state_next = ST_WRITE;
                end else begin
                    state_next = ST_READ;
                end
            end else begin
                state_next    = ST_IDLE;
                wait_cnt_next = 5'd0;
            end
        end
    end

    always_comb begin
        HREADY_out  = data_ready;
        HRESP       = RESP_OKAY;
        HRDATA      = 32'd0;
        Menable     = 1'b0;
        Mwrite      = 4'b0000;
        MAddress    = 32'd0;
        MWrite_data = 32'd0;

        if ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) begin
            HRESP = RESP_ERROR;
        end

        // The read is re-issued every cycle so MRead_data holds until the ready cycle.
        if (state_reg == ST_READ) begin
            Menable  = 1'b1;
            MAddress = {word_addr_reg, 2'b00};
        end

        if (read_ready) begin
            HRDATA = MRead_data;
        end

        if (write_ready) begin
            Menable     = 1'b1;
            Mwrite      = lane_strb;
            MAddress    = {word_addr_reg, 2'b00};
            MWrite_data = HWDATA;
        end
    end

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Self-checking bench: two responders (0 and 3 wait states), each backed by a behavioural SRAM.
module tb_ahb_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic        sel3;
    logic        HSEL0, HSEL3;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;

    logic [31:0] hrdata0, hrdata3, maddr0, maddr3, mwd0, mwd3, mrd0, mrd3;
    logic        ready0, ready3, men0, men3;
    logic [1:0]  resp0, resp3;
    logic [3:0]  mwr0, mwr3;

    logic [31:0] cur_hrdata, cur_maddr;
    logic        cur_ready, cur_menable;
    logic [1:0]  cur_resp;
    logic [3:0]  cur_mwrite;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign HREADY      = sel3 ? ready3 : ready0;
    assign cur_hrdata  = sel3 ? hrdata3 : hrdata0;
    assign cur_maddr   = sel3 ? maddr3 : maddr0;
    assign cur_ready   = sel3 ? ready3 : ready0;
    assign cur_menable = sel3 ? men3 : men0;
    assign cur_resp    = sel3 ? resp3 : resp0;
    assign cur_mwrite  = sel3 ? mwr3 : mwr0;

    ahb_sram_responder #(.WAIT_STATES(0), .MEM_BYTES(32'h0001_0000)) dut0 (
        .clk(clk), .rst(rst), .HSEL(HSEL0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(hrdata0), .HREADY_out(ready0), .HRESP(resp0), .MAddress(maddr0),
        .MWrite_data(mwd0), .Mwrite(mwr0), .Menable(men0), .MRead_data(mrd0)
    );

    ahb_sram_responder #(.WAIT_STATES(3), .MEM_BYTES(32'h0001_0000)) dut3 (
        .clk(clk), .rst(rst), .HSEL(HSEL3), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(hrdata3), .HREADY_out(ready3), .HRESP(resp3), .MAddress(maddr3),
        .MWrite_data(mwd3), .Mwrite(mwr3), .Menable(men3), .MRead_data(mrd3)
    );

    // Behavioural SRAMs: word i initialised to {16'hA5C3, i}
    logic [31:0] mem0 [0:16383];
    logic [31:0] mem3 [0:16383];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16384; i++) mem0[i] <= {16'hA5C3, 16'(i)};
        end else if (men0) begin
            if (mwr0 == 4'b0000) mrd0 <= mem0[maddr0[15:2]];
            else for (int b = 0; b < 4; b++)
                if (mwr0[b]) mem0[maddr0[15:2]][8*b +: 8] <= mwd0[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16384; i++) mem3[i] <= {16'hA5C3, 16'(i)};
        end else if (men3) begin
            if (mwr3 == 4'b0000) mrd3 <= mem3[maddr3[15:2]];
            else for (int b = 0; b < 4; b++)
                if (mwr3[b]) mem3[maddr3[15:2]][8*b +: 8] <= mwd3[8*b +: 8];
        end
    end

    typedef struct {
        logic        dut3;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
        int          exp_low;
    } vec_t;

    vec_t vecs[19];
    vec_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag, input logic [31:0] hrdata, input logic ready,
                                       input logic [1:0] resp, input logic men, input logic [3:0] mwr,
                                       input logic [31:0] maddr, input logic [31:0] mwd);
        check({tag, " HREADY_out"}, 32'(ready), 32'd1);
        check({tag, " HRESP"}, 32'(resp), 32'd0);
        check({tag, " HRDATA"}, hrdata, 32'd0);
        check({tag, " Menable"}, 32'(men), 32'd0);
        check({tag, " Mwrite"}, 32'(mwr), 32'd0);
        check({tag, " MAddress"}, maddr, 32'd0);
        check({tag, " MWrite_data"}, mwd, 32'd0);
    endtask

    // One non-pipelined transfer: address phase, then data phase until HREADY_out.
    task automatic run_xfer(input vec_t v, input string tag);
        vec_t e;
        int   low, stray, bad_resp;
        bit   done;
        @(posedge clk); #1;
        sel3   = v.dut3;
        HSEL0  = !v.dut3;
        HSEL3  = v.dut3;
        HADDR  = v.addr;
        HTRANS = 2'b10;
        HWRITE = v.wr;
        HSIZE  = v.size;
        sb_q.push_back(v);
        @(posedge clk); #1;
        HSEL0  = 1'b0;
        HSEL3  = 1'b0;
        HTRANS = 2'b00;
        HWDATA = v.wdata;
        low = 0; stray = 0; bad_resp = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (cur_ready) begin
                done = 1'b1;
            end else begin
                low++;
                if (cur_resp !== v.exp_resp) bad_resp++;
                if (cur_mwrite !== 4'b0000) stray++;
                if (v.wr && cur_menable) stray++;
            end
            if (v.exp_resp == 2'b01 && cur_menable) stray++;
        end
        e = sb_q.pop_front();
        check({tag, " completes"}, 32'(done), 32'd1);
        if (done) begin
            check({tag, " wait cycles"}, 32'(low), 32'(e.exp_low));
            check({tag, " HRESP"}, 32'(cur_resp), 32'(e.exp_resp));
            check({tag, " HRDATA"}, cur_hrdata, e.exp_rdata);
            check({tag, " Mwrite"}, 32'(cur_mwrite), 32'(e.exp_strb));
            check({tag, " Menable"}, 32'(cur_menable), (e.exp_resp == 2'b00) ? 32'd1 : 32'd0);
            if (e.exp_resp == 2'b00)
                check({tag, " MAddress"}, cur_maddr, {e.addr[31:2], 2'b00});
            check({tag, " wait HRESP"}, 32'(bad_resp), 32'd0);
            check({tag, " stray SRAM activity"}, 32'(stray), 32'd0);
        end
        $display("xfer %s: dut%0d %s addr=%h size=%0d wdata=%h -> resp=%0d rdata=%h strb=%b waits=%0d",
                 tag, v.dut3 ? 3 : 0, v.wr ? "WR" : "RD", v.addr, v.size, v.wdata,
                 cur_resp, cur_hrdata, cur_mwrite, low);
    endtask

    // Four SEQ word writes then four reads on the zero-wait responder, fully pipelined.
    task automatic run_burst();
        vec_t bv[8];
        vec_t e;
        int   ai, di, cyc;
        bit   rdy;
        for (int k = 0; k < 4; k++) begin
            bv[k]   = '{1'b0, 1'b1, 32'h300 + 32'(4*k), 3'd2, 32'h1111_0000 + 32'(k) * 32'h0101,
                        2'b00, 32'h0, 4'hF, 0};
            bv[k+4] = '{1'b0, 1'b0, 32'h300 + 32'(4*k), 3'd2, 32'h0,
                        2'b00, 32'h1111_0000 + 32'(k) * 32'h0101, 4'h0, 1};
        end
        ai = 0; di = -1; cyc = 0;
        sel3 = 1'b0;
        @(posedge clk);
        for (int g = 0; g < 60 && (ai < 8 || di >= 0); g++) begin
            #1;
            if (ai < 8) begin
                HSEL0  = 1'b1;
                HADDR  = bv[ai].addr;
                HTRANS = (ai == 0 || ai == 4) ? 2'b10 : 2'b11;
                HWRITE = bv[ai].wr;
                HSIZE  = bv[ai].size;
            end else begin
                HSEL0  = 1'b0;
                HTRANS = 2'b00;
            end
            HWDATA = (di >= 0) ? bv[di].wdata : 32'h0;
            @(negedge clk);
            rdy = ready0;
            if (di >= 0) begin
                cyc++;
                if (rdy) begin
                    e = sb_q.pop_front();
                    check($sformatf("burst %0d HRESP", di), 32'(resp0), 32'(e.exp_resp));
                    check($sformatf("burst %0d HRDATA", di), hrdata0, e.exp_rdata);
                    check($sformatf("burst %0d Mwrite", di), 32'(mwr0), 32'(e.exp_strb));
                    $display("burst %0d: %s addr=%h -> rdata=%h strb=%b", di,
                             e.wr ? "WR" : "RD", e.addr, hrdata0, mwr0);
                end
            end
            @(posedge clk);
            if (rdy) begin
                if (ai < 8) begin
                    sb_q.push_back(bv[ai]);
                    di = ai;
                    ai++;
                end else begin
                    di = -1;
                end
            end
        end
        #1;
        HSEL0  = 1'b0;
        HTRANS = 2'b00;
        check("burst completes", 32'((ai == 8) && (di == -1)), 32'd1);
        check("burst data-phase cycles", 32'(cyc), 32'd12);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        rst = 1'b1; mem_init = 1'b1; sel3 = 1'b0;
        HSEL0 = 1'b0; HSEL3 = 1'b0; HADDR = 32'h0; HTRANS = 2'b00;
        HWRITE = 1'b0; HSIZE = 3'd0; HWDATA = 32'h0;

        //         dut3  wr    addr           size  wdata          resp   rdata          strb  low
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0100, 3'd2, 32'hDEAD_BEEF, 2'b00, 32'h0,         4'hF, 0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0100, 3'd2, 32'h0,         2'b00, 32'hDEAD_BEEF, 4'h0, 1};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0103, 3'd0, 32'hAA00_0000, 2'b00, 32'h0,         4'h8, 0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0100, 3'd1, 32'h0000_1234, 2'b00, 32'h0,         4'h3, 0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0100, 3'd2, 32'h0,         2'b00, 32'hAAAD_1234, 4'h0, 1};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0105, 3'd0, 32'h0000_7700, 2'b00, 32'h0,         4'h2, 0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0106, 3'd1, 32'hBEEF_0000, 2'b00, 32'h0,         4'hC, 0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_0104, 3'd2, 32'h0,         2'b00, 32'hBEEF_7741, 4'h0, 1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0102, 3'd2, 32'h0,         2'b01, 32'h0,         4'h0, 1};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0100, 3'd3, 32'hFFFF_FFFF, 2'b01, 32'h0,         4'h0, 1};
        vecs[10] = '{1'b0, 1'b0, 32'h0001_0000, 3'd2, 32'h0,         2'b01, 32'h0,         4'h0, 1};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0101, 3'd1, 32'hFFFF_FFFF, 2'b01, 32'h0,         4'h0, 1};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_FFFC, 3'd2, 32'h0,         2'b00, 32'hA5C3_3FFF, 4'h0, 1};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_0100, 3'd2, 32'h0,         2'b00, 32'hAAAD_1234, 4'h0, 1};
        vecs[14] = '{1'b1, 1'b1, 32'h0000_0200, 3'd2, 32'h1234_5678, 2'b00, 32'h0,         4'hF, 3};
        vecs[15] = '{1'b1, 1'b0, 32'h0000_0200, 3'd2, 32'h0,         2'b00, 32'h1234_5678, 4'h0, 4};
        vecs[16] = '{1'b1, 1'b0, 32'h0001_0004, 3'd2, 32'h0,         2'b01, 32'h0,         4'h0, 1};
        vecs[17] = '{1'b1, 1'b1, 32'h0000_0202, 3'd1, 32'hCAFE_0000, 2'b00, 32'h0,         4'hC, 3};
        vecs[18] = '{1'b1, 1'b0, 32'h0000_0200, 3'd2, 32'h0,         2'b00, 32'hCAFE_5678, 4'h0, 4};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset dut0", hrdata0, ready0, resp0, men0, mwr0, maddr0, mwd0);
        check_reset_outputs("reset dut3", hrdata3, ready3, resp3, men3, mwr3, maddr3, mwd3);

        for (int i = 0; i < 19; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        run_burst();

        // Reset during D1 of a 3-wait write: the write must never reach the SRAM.
        stray = 0;
        @(posedge clk); #1;
        sel3 = 1'b1; HSEL3 = 1'b1; HADDR = 32'h400; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge clk); #1;
        HSEL3 = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFF_FFFF;
        @(negedge clk);
        if (mwr3 !== 4'b0000 || men3) stray++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        if (mwr3 !== 4'b0000 || men3) stray++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid-write reset dut3", hrdata3, ready3, resp3, men3, mwr3, maddr3, mwd3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mwr3 !== 4'b0000 || men3) stray++;
        end
        check("mid-write reset strobes", 32'(stray), 32'd0);
        $display("reset mid-write: stray SRAM cycles=%0d", stray);
        run_xfer('{1'b1, 1'b0, 32'h0000_0400, 3'd2, 32'h0, 2'b00, 32'hA5C3_0100, 4'h0, 4},
                 "post-reset read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
